// File: rtl/debug_rx_loader.sv
// -----------------------------------------------------------------------------
// debug_rx_loader
//
// Receive-side control FSM of the debugger unit. Sits between the UART
// receiver and the pipeline, decodes single-byte host commands and, for a
// load command, packs incoming bytes MSB-first into instruction words that
// are written to instruction memory one word per write strobe. A load ends
// when the halt word arrives (which is itself written).
//
// Commands decoded in IDLE:
//   0x4C 'L' : start a load at address 0
//   0x52 'R' : one-cycle run pulse
//   0x53 'S' : one-cycle step pulse
//   others   : ignored
//
// Optional build macro:
//   LOADER_TIMEOUT_EN : abort a load with os_error when no byte arrives
//                       for TIMEOUT_CYCLES cycles while in LOAD.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   i_rx_data    in   [7:0] received byte, valid while is_rx_done is high
//   is_rx_done   in   one-cycle "byte received" strobe
//   o_mem_we     out  instruction-memory write enable (one-cycle pulse)
//   o_mem_addr   out  [ADDR_W-1:0] word-aligned byte address, held between writes
//   o_mem_data   out  [DATA_W-1:0] write data, held between writes
//   os_run       out  one-cycle run pulse
//   os_step      out  one-cycle step pulse
//   os_load_done out  one-cycle pulse: load ended with the halt word
//   os_error     out  one-cycle pulse: load aborted (overflow / timeout)
//   o_busy       out  high whenever the FSM is not in IDLE
//
// All outputs come from registers or from decoding the registered state;
// nothing passes combinationally from an input to an output.
// -----------------------------------------------------------------------------
module debug_rx_loader #(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 10,
    parameter int                MEM_WORDS      = 256,
    parameter logic [DATA_W-1:0] HALT_WORD      = {DATA_W{1'b1}},
    parameter int                TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              is_rx_done,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              os_run,
    output logic              os_step,
    output logic              os_load_done,
    output logic              os_error,
    output logic              o_busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = $clog2(BYTES) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((MEM_WORDS - 1) * 4);

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    // Parameter sanity: word must be whole bytes, the memory must fit the
    // address space, and the timeout must leave room for at least one count.
    if ((DATA_W % 8) != 0 || DATA_W < 16 || (MEM_WORDS * 4) > (2 ** ADDR_W)
        || MEM_WORDS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("debug_rx_loader: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [BC_W-1:0]     byte_cnt_r;
    // Only the low DATA_W-8 bits of the word ever survive the next shift,
    // so the top byte is not stored here; the full word lives in mem_data_r.
    logic [DATA_W-9:0]   part_r;
    logic [DATA_W-1:0]   shift_s;
    logic                last_byte_s;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_data_r;
    logic                run_r;
    logic                step_r;

    assign shift_s     = {part_r, i_rx_data};
    assign last_byte_s = (byte_cnt_r == BC_W'(BYTES - 1));

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             tmo_hit_s;

    assign tmo_hit_s = (state_r == ST_LOAD) && !is_rx_done
                       && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // Inter-byte idle counter: runs only in LOAD, cleared by every strobe.
    // It is already zero on entry because it is held clear outside LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (state_r != ST_LOAD || is_rx_done) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (is_rx_done && (i_rx_data == CMD_LOAD)) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (is_rx_done && last_byte_s) begin
                    state_s = ST_WRITE;
`ifdef LOADER_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    state_s = ST_ERROR;
`endif
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_WRITE: begin
                // The halt check has priority: a halt word in the last slot
                // is a clean finish, not an overflow.
                if (mem_data_r == HALT_WORD) begin
                    state_s = ST_DONE;
                end else if (addr_r == LAST_ADDR) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            ST_ERROR: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Datapath: command pulses, byte assembly, address counter and the
    // held write address/data presented to memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= '0;
            byte_cnt_r <= '0;
            part_r     <= '0;
            mem_addr_r <= '0;
            mem_data_r <= '0;
            run_r      <= 1'b0;
            step_r     <= 1'b0;
        end else begin
            run_r  <= 1'b0;
            step_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (is_rx_done) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                addr_r     <= '0;
                                byte_cnt_r <= '0;
                            end
                            CMD_RUN:  run_r  <= 1'b1;
                            CMD_STEP: step_r <= 1'b1;
                            default:  run_r  <= 1'b0;
                        endcase
                    end else begin
                        run_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (is_rx_done) begin
                        part_r <= shift_s[DATA_W-9:0];
                        if (last_byte_s) begin
                            // Capture the complete word and its address now so
                            // they are stable for the single WRITE cycle and
                            // held afterwards.
                            byte_cnt_r <= '0;
                            mem_data_r <= shift_s;
                            mem_addr_r <= addr_r;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BC_W'(1);
                        end
                    end else begin
                        byte_cnt_r <= byte_cnt_r;
                    end
                end
                ST_WRITE: begin
                    if (state_s == ST_LOAD) begin
                        addr_r <= addr_r + ADDR_W'(4);
                        // A strobe in the WRITE cycle is byte 1 of the next
                        // word; on the DONE/ERROR paths it is dropped.
                        if (is_rx_done) begin
                            part_r     <= shift_s[DATA_W-9:0];
                            byte_cnt_r <= BC_W'(1);
                        end else begin
                            byte_cnt_r <= '0;
                        end
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                default: begin
                    addr_r <= addr_r;
                end
            endcase
        end
    end

    assign o_mem_we     = (state_r == ST_WRITE);
    assign o_mem_addr   = mem_addr_r;
    assign o_mem_data   = mem_data_r;
    assign os_run       = run_r;
    assign os_step      = step_r;
    assign os_load_done = (state_r == ST_DONE);
    assign os_error     = (state_r == ST_ERROR);
    assign o_busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_debug_rx_loader.sv
module tb_debug_rx_loader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_done = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              run, step, load_done, err, busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, run_cnt = 0, step_cnt = 0, done_cnt = 0, err_cnt = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    debug_rx_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(4),
        .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .i_rx_data(rx_data), .is_rx_done(rx_done),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
        .os_run(run), .os_step(step), .os_load_done(load_done),
        .os_error(err), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write is popped against the expected queue.
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (!rst) begin
            if (mem_we === 1'b1) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_data} !== e) begin
                        errors++;
                        $display("FAIL write_data got addr=%h data=%h exp addr=%h data=%h",
                                 mem_addr, mem_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                    end
                end
            end
            if (run === 1'b1)       run_cnt++;
            if (step === 1'b1)      step_cnt++;
            if (load_done === 1'b1) done_cnt++;
            if (err === 1'b1)       err_cnt++;
        end
    end

    task automatic clear_counts();
        wr_cnt = 0; run_cnt = 0; step_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    // One strobe; returns at the negedge right after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_data = b; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a);
        exp_q.push_back({a, w});
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_idle_timeout busy=%b exp 0", name, busy); end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes left=%0d exp 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_data, run, step, load_done, err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs we=%b addr=%h data=%h run=%b step=%b done=%b err=%b busy=%b exp all 0",
                     mem_we, mem_addr, mem_data, run, step, load_done, err, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_halt();
        clear_counts();
        send_byte(8'h4C);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b exp 1", busy); end
        send_word(32'h0000_002A, 10'd0);
        // Last-byte strobe at N gives the write at N+1.
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL write_latency we=%b exp 1", mem_we); end
        send_word(32'hFFFF_FFFF, 10'd4);
        @(negedge clk);
        checks++;
        if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_timing got %b exp 1", load_done); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL halt_busy_after got %b exp 0", busy); end
        checks++;
        if ({mem_addr, mem_data} !== {10'd4, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL hold_addr_data got %h/%h exp 004/ffffffff", mem_addr, mem_data);
        end
        wait_idle("halt");
        checks++;
        if (wr_cnt != 2 || done_cnt != 1 || err_cnt != 0) begin
            errors++; $display("FAIL halt_counts wr=%0d done=%0d err=%0d exp 2/1/0", wr_cnt, done_cnt, err_cnt);
        end
        check_queue_empty("halt");
    endtask

    task automatic test_commands();
        clear_counts();
        send_byte(8'h52);
        checks++;
        if (run !== 1'b1) begin errors++; $display("FAIL run_timing got %b exp 1", run); end
        repeat (3) @(negedge clk);
        send_byte(8'h53);
        checks++;
        if (step !== 1'b1) begin errors++; $display("FAIL step_timing got %b exp 1", step); end
        repeat (3) @(negedge clk);
        send_byte(8'h7A);
        repeat (3) @(negedge clk);
        checks++;
        if (run_cnt != 1 || step_cnt != 1 || wr_cnt != 0 || done_cnt != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL cmd_counts run=%0d step=%0d wr=%0d done=%0d err=%0d exp 1/1/0/0/0",
                     run_cnt, step_cnt, wr_cnt, done_cnt, err_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL cmd_busy got %b exp 0", busy); end
    endtask

    task automatic test_overflow();
        clear_counts();
        send_byte(8'h4C);
        send_word(32'h1111_1111, 10'd0);
        send_word(32'h2222_2222, 10'd4);
        send_word(32'h3333_3333, 10'd8);
        send_word(32'h4444_4444, 10'd12);
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL overflow_error got %b exp 1", err); end
        wait_idle("overflow");
        checks++;
        if (wr_cnt != 4 || err_cnt != 1 || done_cnt != 0) begin
            errors++; $display("FAIL overflow_counts wr=%0d err=%0d done=%0d exp 4/1/0", wr_cnt, err_cnt, done_cnt);
        end
        check_queue_empty("overflow");
        send_byte(8'h52);
        @(negedge clk);
        checks++;
        if (run_cnt != 1) begin errors++; $display("FAIL overflow_then_run run=%0d exp 1", run_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s [12];
        s = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
        clear_counts();
        send_byte(8'h4C);
        exp_q.push_back({10'd0, 32'hDEAD_BEEF});
        exp_q.push_back({10'd4, 32'h0123_4567});
        exp_q.push_back({10'd8, 32'hFFFF_FFFF});
        // One strobe per cycle: byte 5 and byte 9 land in WRITE cycles.
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            rx_data = s[i]; rx_done = 1'b1;
            @(negedge clk);
        end
        rx_done = 1'b0;
        wait_idle("b2b");
        checks++;
        if (wr_cnt != 3 || done_cnt != 1 || err_cnt != 0) begin
            errors++; $display("FAIL b2b_counts wr=%0d done=%0d err=%0d exp 3/1/0", wr_cnt, done_cnt, err_cnt);
        end
        check_queue_empty("b2b");
    endtask

    task automatic test_reset_mid_load();
        clear_counts();
        send_byte(8'h4C);
        send_byte(8'h12);
        send_byte(8'h34);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_addr, mem_data, run, step, load_done, err, busy} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs we=%b addr=%h data=%h busy=%b exp all 0", mem_we, mem_addr, mem_data, busy);
        end
        rst = 1'b0;
        send_byte(8'h4C);
        send_word(32'hAABB_CCDD, 10'd0);
        send_word(32'hFFFF_FFFF, 10'd4);
        wait_idle("midreset");
        checks++;
        if (wr_cnt != 2 || done_cnt != 1) begin
            errors++; $display("FAIL midreset_counts wr=%0d done=%0d exp 2/1", wr_cnt, done_cnt);
        end
        check_queue_empty("midreset");
    endtask

    task automatic test_timeout();
        clear_counts();
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (120) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
        checks++;
        if (err_cnt != 1 || wr_cnt != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_abort err=%0d wr=%0d busy=%b exp 1/0/0", err_cnt, wr_cnt, busy);
        end
`else
        checks++;
        if (err_cnt != 0 || wr_cnt != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL no_timeout_wait err=%0d wr=%0d busy=%b exp 0/0/1", err_cnt, wr_cnt, busy);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_cleanup busy=%b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_load_halt();
        test_commands();
        test_overflow();
        test_back_to_back();
        test_reset_mid_load();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
